// File: rtl/pkt_arb_4_avlstrm_pkg.sv
// Shared types and constants for the 4-input packet arbiter.
package pkt_arb_pkg;

  localparam int NUM_IN = 4;
  localparam int IDX_W  = $clog2(NUM_IN);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/pkt_arb_4_avlstrm_if.sv
// Avalon-ST stream bundle; tx drives a stream, rx consumes one.
interface avl_stream_if #(
  parameter int DWIDTH = 512,
  parameter int EWIDTH = 6
);
  logic [DWIDTH-1:0] data;
  logic              valid;
  logic              ready;
  logic              sop;
  logic              eop;
  logic [EWIDTH-1:0] empty;

  modport tx (output data, valid, sop, eop, empty, input ready);
  modport rx (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/pkt_arb_4_avlstrm_rr_pick4.sv
// Round-robin pick among four requests, scanning upward from last+1.
module rr_pick4
  import pkt_arb_pkg::*;
(
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [IDX_W-1:0]  pick,
  output logic              any
);

  logic [IDX_W-1:0] idx;

  // First set request after 'last', wrapping; 'last' itself is checked last.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = last + IDX_W'(k);
      if (!any && req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_arb_4_avlstrm.sv
// Packet-granular 4-input round-robin arbiter with a registered Avalon-ST output.
module pkt_arb_4_avlstrm
  import pkt_arb_pkg::*;
#(
  parameter int DWIDTH = 512,
  parameter int EWIDTH = 6,
  parameter int CWIDTH = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  avl_stream_if.rx          in0,
  avl_stream_if.rx          in1,
  avl_stream_if.rx          in2,
  avl_stream_if.rx          in3,
  avl_stream_if.tx          out,
  input  logic [NUM_IN-1:0] arb_mask,
  output logic [IDX_W-1:0]  cur_grant,
  output logic              busy,
  output logic [CWIDTH-1:0] pkt_cnt0,
  output logic [CWIDTH-1:0] pkt_cnt1,
  output logic [CWIDTH-1:0] pkt_cnt2,
  output logic [CWIDTH-1:0] pkt_cnt3
);

  // Inputs gathered into arrays so they can be indexed by the grant.
  logic [DWIDTH-1:0] in_data  [NUM_IN];
  logic [EWIDTH-1:0] in_empty [NUM_IN];
  logic [NUM_IN-1:0] in_valid, in_sop, in_eop, in_ready;

  assign in_data[0]  = in0.data;   assign in_data[1]  = in1.data;
  assign in_data[2]  = in2.data;   assign in_data[3]  = in3.data;
  assign in_empty[0] = in0.empty;  assign in_empty[1] = in1.empty;
  assign in_empty[2] = in2.empty;  assign in_empty[3] = in3.empty;
  assign in_valid    = {in3.valid, in2.valid, in1.valid, in0.valid};
  assign in_sop      = {in3.sop,   in2.sop,   in1.sop,   in0.sop};
  assign in_eop      = {in3.eop,   in2.eop,   in1.eop,   in0.eop};
  assign in0.ready   = in_ready[0];
  assign in1.ready   = in_ready[1];
  assign in2.ready   = in_ready[2];
  assign in3.ready   = in_ready[3];

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [CWIDTH-1:0] pkt_cnt_q [NUM_IN];
  logic [CWIDTH-1:0] pkt_cnt_d [NUM_IN];

  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic [EWIDTH-1:0] out_empty_q, out_empty_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;

  logic              locked;
  logic              load;
  logic              accept;
  logic [NUM_IN-1:0] req;
  logic [IDX_W-1:0]  pick;
  logic              pick_any;

  assign locked = (state_q == LOCKED);
  // Output register can take a new beat when empty or being drained this cycle.
  assign load   = !out_valid_q || out.ready;
  assign accept = locked && in_valid[grant_q] && load;
  assign req    = in_valid & arb_mask;

  // Only the granted input sees ready, and only while the output can load.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
    assign in_ready[gi] = locked && (grant_q == IDX_W'(gi)) && load;
  end

  rr_pick4 u_pick (
    .req  (req),
    .last (last_grant_q),
    .pick (pick),
    .any  (pick_any)
  );

  // Arbitration FSM: grant in IDLE, hold until the granted input's eop is accepted.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    for (int i = 0; i < NUM_IN; i++) pkt_cnt_d[i] = pkt_cnt_q[i];
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && in_eop[grant_q]) begin
          last_grant_d       = grant_q;
          pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + CWIDTH'(1);
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: load the accepted beat (or a bubble) whenever the register is free.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_empty_d = out_empty_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    if (load) begin
      out_valid_d = accept;
      out_data_d  = in_data[grant_q];
      out_empty_d = in_empty[grant_q];
      out_sop_d   = in_sop[grant_q];
      out_eop_d   = in_eop[grant_q];
    end
  end

  // Control state; reset drops any packet in flight and restarts arbitration at in0.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_IN - 1);
      out_valid_q  <= 1'b0;
      for (int i = 0; i < NUM_IN; i++) pkt_cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      for (int i = 0; i < NUM_IN; i++) pkt_cnt_q[i] <= pkt_cnt_d[i];
    end
  end

  // Payload register is qualified by out_valid_q, so it needs no reset.
  always_ff @(posedge Clk) begin
    out_data_q  <= out_data_d;
    out_empty_q <= out_empty_d;
    out_sop_q   <= out_sop_d;
    out_eop_q   <= out_eop_d;
  end

  assign out.valid = out_valid_q;
  assign out.data  = out_data_q;
  assign out.empty = out_empty_q;
  assign out.sop   = out_sop_q;
  assign out.eop   = out_eop_q;
  assign cur_grant = grant_q;
  assign busy      = locked;
  assign pkt_cnt0  = pkt_cnt_q[0];
  assign pkt_cnt1  = pkt_cnt_q[1];
  assign pkt_cnt2  = pkt_cnt_q[2];
  assign pkt_cnt3  = pkt_cnt_q[3];

endmodule

// File: tb/tb_pkt_arb_4_avlstrm.sv
// Directed bench for pkt_arb_4_avlstrm: reset, single packet, round-robin,
// backpressure, masking, single-beat packets and reset mid-packet.
module tb_pkt_arb_4_avlstrm;

  localparam int DW = 32;
  localparam int EW = 6;
  localparam int CW = 16;

  logic          Clk;
  logic          Rst_n;
  logic [3:0]    arb_mask;
  logic [1:0]    cur_grant;
  logic          busy;
  logic [CW-1:0] cnt [4];
  logic          out_rdy;

  int total = 0;
  int bad   = 0;

  avl_stream_if #(.DWIDTH(DW), .EWIDTH(EW)) i0 ();
  avl_stream_if #(.DWIDTH(DW), .EWIDTH(EW)) i1 ();
  avl_stream_if #(.DWIDTH(DW), .EWIDTH(EW)) i2 ();
  avl_stream_if #(.DWIDTH(DW), .EWIDTH(EW)) i3 ();
  avl_stream_if #(.DWIDTH(DW), .EWIDTH(EW)) o ();

  pkt_arb_4_avlstrm #(.DWIDTH(DW), .EWIDTH(EW), .CWIDTH(CW)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .in0       (i0),
    .in1       (i1),
    .in2       (i2),
    .in3       (i3),
    .out       (o),
    .arb_mask  (arb_mask),
    .cur_grant (cur_grant),
    .busy      (busy),
    .pkt_cnt0  (cnt[0]),
    .pkt_cnt1  (cnt[1]),
    .pkt_cnt2  (cnt[2]),
    .pkt_cnt3  (cnt[3])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Source queues: beat = {data, sop, eop, empty}; valid while the queue is non-empty.
  logic [39:0] src_mem [4][64];
  int          src_head [4] = '{default: 0};
  int          src_tail [4] = '{default: 0};
  logic [39:0] src_beat [4];
  logic [3:0]  src_valid;
  logic [3:0]  src_ready;

  for (genvar gi = 0; gi < 4; gi++) begin : g_src
    assign src_valid[gi] = (src_head[gi] != src_tail[gi]);
    assign src_beat[gi]  = src_mem[gi][src_head[gi][5:0]];
  end

  assign i0.valid = src_valid[0]; assign i0.data = src_beat[0][39:8];
  assign i0.sop = src_beat[0][7]; assign i0.eop = src_beat[0][6]; assign i0.empty = src_beat[0][5:0];
  assign i1.valid = src_valid[1]; assign i1.data = src_beat[1][39:8];
  assign i1.sop = src_beat[1][7]; assign i1.eop = src_beat[1][6]; assign i1.empty = src_beat[1][5:0];
  assign i2.valid = src_valid[2]; assign i2.data = src_beat[2][39:8];
  assign i2.sop = src_beat[2][7]; assign i2.eop = src_beat[2][6]; assign i2.empty = src_beat[2][5:0];
  assign i3.valid = src_valid[3]; assign i3.data = src_beat[3][39:8];
  assign i3.sop = src_beat[3][7]; assign i3.eop = src_beat[3][6]; assign i3.empty = src_beat[3][5:0];
  assign src_ready = {i3.ready, i2.ready, i1.ready, i0.ready};
  assign o.ready   = out_rdy;

  // Pop a source beat on every handshake.
  always @(posedge Clk) begin
    for (int i = 0; i < 4; i++)
      if (Rst_n && src_valid[i] && src_ready[i]) src_head[i] <= src_head[i] + 1;
  end

  // Collect every beat leaving the arbiter together with its cycle number.
  logic [39:0] out_q [$];
  int          out_cyc [$];
  int          cyc = 0;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Rst_n && o.valid && out_rdy) begin
      out_q.push_back({o.data, o.sop, o.eop, o.empty});
      out_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] enc(input int port, input int pkt, input int beat);
    return {port[7:0], pkt[7:0], beat[7:0], 8'hA5};
  endfunction

  function automatic logic [5:0] emp(input int port, input int beat);
    return 6'(port * 8 + beat);
  endfunction

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int port, input int pkt, input int nb);
    for (int b = 0; b < nb; b++) begin
      src_mem[port][src_tail[port][5:0]] = {enc(port, pkt, b), 1'(b == 0), 1'(b == nb - 1), emp(port, b)};
      src_tail[port] = src_tail[port] + 1;
    end
  endtask

  task automatic wait_cnt(input int port, input int target, input string tag);
    for (int n = 0; n < 200 && cnt[port] != CW'(target); n++) step();
    chk(tag, cnt[port], target);
  endtask

  task automatic wait_busy(input string tag);
    for (int n = 0; n < 50 && !busy; n++) step();
    chk(tag, busy, 1);
  endtask

  task automatic expect_pkt(input int port, input int pkt, input int nb);
    logic [39:0] got;
    logic [39:0] want;
    for (int b = 0; b < nb; b++) begin
      want = {enc(port, pkt, b), 1'(b == 0), 1'(b == nb - 1), emp(port, b)};
      if (out_q.size() > 0) got = out_q.pop_front();
      else got = 'x;
      $display("beat port=%0d pkt=%0h beat=%0d got=%h want=%h", port, pkt, b, got, want);
      chk("out_beat", got, want);
    end
  endtask

  initial begin
    Rst_n    = 1'b0;
    out_rdy  = 1'b1;
    arb_mask = 4'hF;

    // Reset state
    step(); step();
    chk("rst_out_valid", o.valid, 0);
    chk("rst_ready", src_ready, 4'h0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_grant", cur_grant, 0);
    for (int i = 0; i < 4; i++) chk("rst_pkt_cnt", cnt[i], 0);
    Rst_n = 1'b1;
    step();

    // Single 3-beat packet on in0: ready one cycle after valid, beats follow
    push_pkt(0, 8'h01, 3);
    #1;
    chk("t1_ready_lag", src_ready[0], 0);
    chk("t1_busy_idle", busy, 0);
    step();
    chk("t1_ready", src_ready[0], 1);
    chk("t1_busy", busy, 1);
    chk("t1_grant", cur_grant, 0);
    chk("t1_out_valid_n1", o.valid, 0);
    step();
    chk("t1_b0_valid", o.valid, 1);
    chk("t1_b0_data", o.data, enc(0, 1, 0));
    chk("t1_b0_sop_eop", {o.sop, o.eop}, 2'b10);
    step();
    chk("t1_b1_data", o.data, enc(0, 1, 1));
    chk("t1_b1_sop_eop", {o.sop, o.eop}, 2'b00);
    step();
    chk("t1_b2_data", o.data, enc(0, 1, 2));
    chk("t1_b2_sop_eop", {o.sop, o.eop}, 2'b01);
    chk("t1_b2_empty", o.empty, emp(0, 2));
    chk("t1_busy_done", busy, 0);
    chk("t1_cnt0", cnt[0], 1);
    step();
    chk("t1_out_idle", o.valid, 0);
    out_q.delete(); out_cyc.delete();

    // All four inputs, five 2-beat packets each; last grant was 0 so order starts at 1
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 5; k++) push_pkt(p, 8'h20 + k, 2);
    wait_cnt(0, 6, "t2_cnt0");
    chk("t2_cnt1", cnt[1], 5);
    chk("t2_cnt2", cnt[2], 5);
    chk("t2_cnt3", cnt[3], 5);
    step(); step();
    for (int k = 0; k < 20; k++) expect_pkt((1 + k) % 4, 8'h20 + k / 4, 2);
    chk("t2_extra_beats", out_q.size(), 0);
    out_cyc.delete();

    // Backpressure on a 4-beat in2 packet: out.ready 1,0,0,1
    push_pkt(2, 8'h30, 4);
    step();
    chk("t3_grant", cur_grant, 2);
    chk("t3_ready", src_ready[2], 1);
    step();
    out_rdy = 1'b0;
    #1;
    chk("t3_ready_bp0", src_ready[2], 0);
    chk("t3_hold_valid0", o.valid, 1);
    step();
    chk("t3_ready_bp1", src_ready[2], 0);
    chk("t3_hold_data", o.data, enc(2, 8'h30, 0));
    out_rdy = 1'b1;
    #1;
    chk("t3_ready_resume", src_ready[2], 1);
    wait_cnt(2, 6, "t3_cnt2");
    step(); step();
    expect_pkt(2, 8'h30, 4);
    chk("t3_extra_beats", out_q.size(), 0);
    out_cyc.delete();

    // Mask 1010: only in1/in3 granted; clearing bit 1 mid-packet lets in1 finish
    arb_mask = 4'b1010;
    push_pkt(3, 8'h40, 2);
    push_pkt(1, 8'h41, 3);
    push_pkt(3, 8'h42, 2);
    push_pkt(1, 8'h43, 2);
    push_pkt(0, 8'h44, 1);
    push_pkt(2, 8'h45, 1);
    for (int n = 0; n < 50 && !(busy && cur_grant == 2'd1); n++) step();
    chk("t4_grant1", {busy, cur_grant}, 3'b101);
    step();
    arb_mask = 4'b1000;
    wait_cnt(3, 7, "t4_cnt3");
    step(); step(); step(); step();
    chk("t4_cnt1_masked", cnt[1], 6);
    chk("t4_idle_masked", busy, 0);
    chk("t4_cnt0", cnt[0], 6);
    chk("t4_cnt2", cnt[2], 6);
    src_tail[0] = src_head[0];
    src_tail[2] = src_head[2];
    step();
    arb_mask = 4'b1010;
    wait_cnt(1, 7, "t4_cnt1");
    step(); step();
    expect_pkt(3, 8'h40, 2);
    expect_pkt(1, 8'h41, 3);
    expect_pkt(3, 8'h42, 2);
    expect_pkt(1, 8'h43, 2);
    chk("t4_extra_beats", out_q.size(), 0);
    out_cyc.delete();

    // Back-to-back single-beat packets on in3: one output beat every 2 cycles
    arb_mask = 4'hF;
    for (int k = 0; k < 4; k++) push_pkt(3, 8'h50 + k, 1);
    wait_cnt(3, 11, "t5_cnt3");
    step(); step();
    chk("t5_beat_count", out_cyc.size(), 4);
    if (out_cyc.size() == 4)
      for (int k = 1; k < 4; k++) chk("t5_spacing", out_cyc[k] - out_cyc[k - 1], 2);
    for (int k = 0; k < 4; k++) expect_pkt(3, 8'h50 + k, 1);
    out_cyc.delete();

    // Reset mid-packet: make in0 the last grant, abort an in2 packet after beat 2
    push_pkt(0, 8'h60, 1);
    wait_cnt(0, 7, "t6_cnt0_pre");
    step(); step();
    push_pkt(2, 8'h61, 5);
    wait_busy("t6_busy");
    chk("t6_grant2", cur_grant, 2);
    step(); step();
    Rst_n = 1'b0;
    for (int i = 0; i < 4; i++) src_tail[i] = src_head[i];
    step();
    chk("t6_out_valid", o.valid, 0);
    chk("t6_ready", src_ready, 4'h0);
    chk("t6_busy_rst", busy, 0);
    chk("t6_grant_rst", cur_grant, 0);
    for (int i = 0; i < 4; i++) chk("t6_cnt_rst", cnt[i], 0);
    Rst_n = 1'b1;
    out_q.delete(); out_cyc.delete();
    push_pkt(1, 8'h70, 1);
    push_pkt(0, 8'h71, 1);
    wait_busy("t6_busy_post");
    chk("t6_first_grant", cur_grant, 0);
    wait_cnt(1, 1, "t6_cnt1");
    step(); step();
    expect_pkt(0, 8'h71, 1);
    expect_pkt(1, 8'h70, 1);
    chk("t6_extra_beats", out_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
